// File: rtl/npc_mem_pkg.sv
// Shared types and default widths for the NPC memory arbiter and the core top.
package npc_mem_pkg;

  // Default bus widths; the core top uses the same constants when wiring the memory port.
  localparam int NPC_ADDR_W = 32;
  localparam int NPC_DATA_W = 32;

  // Sequencer state: pick a requester, present it to memory, wait for the reply.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/npc_mem_arb_pick.sv
// Stateless winner select between the fetch and load/store requesters.
// LSU has fixed priority; a starved IFU overrides it when both are asking.
module npc_mem_arb_pick (
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  input  logic i_ifu_starved,
  output logic o_grant_ifu,
  output logic o_grant_lsu
);

  // Select at most one winner from the currently valid requesters.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant_ifu = 1'b0;
    o_grant_lsu = 1'b0;
    if (i_lsu_valid && !(i_ifu_valid && i_ifu_starved)) begin
      o_grant_lsu = 1'b1;
    end else if (i_ifu_valid) begin
      o_grant_ifu = 1'b1;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Two-requester memory arbiter and sequencer: IFU and LSU share one memory port.
// One transaction in flight at a time; responses are routed back to the owner.
module npc_mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W       = NPC_ADDR_W,
  parameter int DATA_W       = NPC_DATA_W,
  // Consecutive LSU grants with IFU waiting before IFU is forced; must be >= 1.
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  // Instruction fetch requester (read only)
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_resp_valid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  // Load/store requester
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic                i_lsu_wen,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  output logic                o_lsu_resp_valid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  // Shared memory port
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  // Counter just wide enough to hold STARVE_LIMIT itself.
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t             r_state;
  state_t             w_state_next;
  owner_t             r_owner;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_wen;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [MASK_W-1:0]  r_mem_wmask;

  logic               w_starved;
  logic               w_pick_ifu;
  logic               w_pick_lsu;
  logic               w_grant_ifu;
  logic               w_grant_lsu;
  logic               w_mem_req_valid;
  logic               w_resp_fire;

  assign w_starved = (r_starve_cnt == CNT_MAX);

  npc_mem_arb_pick u_pick (
    .i_ifu_valid   (i_ifu_req_valid),
    .i_lsu_valid   (i_lsu_req_valid),
    .i_ifu_starved (w_starved),
    .o_grant_ifu   (w_pick_ifu),
    .o_grant_lsu   (w_pick_lsu)
  );

  // State register; reset drops any in-flight transaction and returns to IDLE.
  // NOTE: sequential state uses non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: grant leaves IDLE, memory handshake leaves REQ, response leaves WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_ifu || w_grant_lsu) w_state_next = ST_REQ;
      ST_REQ:  if (i_mem_req_ready)            w_state_next = ST_WAIT;
      ST_WAIT: if (i_mem_resp_valid)           w_state_next = ST_IDLE;
      default:                                 w_state_next = ST_IDLE;
    endcase
  end

  // Outputs per state; reset masks every handshake so nothing is granted or
  // acknowledged in a cycle whose effect the reset would discard.
  always_comb begin
    w_grant_ifu     = 1'b0;
    w_grant_lsu     = 1'b0;
    w_mem_req_valid = 1'b0;
    w_resp_fire     = 1'b0;
    if (!i_reset) begin
      case (r_state)
        ST_IDLE: begin
          w_grant_ifu = w_pick_ifu;
          w_grant_lsu = w_pick_lsu;
        end
        ST_REQ:  w_mem_req_valid = 1'b1;
        // Responses outside WAIT fall through here and are ignored.
        ST_WAIT: w_resp_fire = i_mem_resp_valid;
        default: ;
      endcase
    end
  end

  // Capture the winner's payload and owner in the grant cycle; later requester
  // changes cannot disturb the transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner     <= OWN_IFU;
      r_mem_addr  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else if (w_grant_lsu) begin
      r_owner     <= OWN_LSU;
      r_mem_addr  <= i_lsu_addr;
      r_mem_wen   <= i_lsu_wen;
      r_mem_wdata <= i_lsu_wdata;
      r_mem_wmask <= i_lsu_wmask;
    end else if (w_grant_ifu) begin
      // Fetches are always plain reads.
      r_owner     <= OWN_IFU;
      r_mem_addr  <= i_ifu_addr;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end
  end

  // Count LSU grants that passed over a waiting IFU; an IFU grant clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ifu) begin
      r_starve_cnt <= '0;
    end else if (w_grant_lsu && i_ifu_req_valid && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign o_ifu_req_ready  = w_grant_ifu;
  assign o_lsu_req_ready  = w_grant_lsu;
  assign o_mem_req_valid  = w_mem_req_valid;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wen        = r_mem_wen;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_mem_wmask      = r_mem_wmask;

  // Response demux: memory data passes straight through to the owner only.
  assign o_ifu_resp_valid = w_resp_fire && (r_owner == OWN_IFU);
  assign o_lsu_resp_valid = w_resp_fire && (r_owner == OWN_LSU);
  assign o_ifu_rdata      = o_ifu_resp_valid ? i_mem_rdata : '0;
  assign o_lsu_rdata      = o_lsu_resp_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Self-checking bench for npc_mem_arbiter: directed scenarios followed by a
// randomized phase, all checked each cycle against a transaction-level model.
module tb_npc_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ifu_v, ifu_rdy, ifu_rv;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rd;
  logic          lsu_v, lsu_rdy, lsu_rv, lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rd;
  logic [MW-1:0] lsu_wmask;
  logic          mem_v, mem_rdy, mem_wen, mem_rv;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  npc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_ifu_req_valid  (ifu_v),
    .o_ifu_req_ready  (ifu_rdy),
    .i_ifu_addr       (ifu_addr),
    .o_ifu_resp_valid (ifu_rv),
    .o_ifu_rdata      (ifu_rd),
    .i_lsu_req_valid  (lsu_v),
    .o_lsu_req_ready  (lsu_rdy),
    .i_lsu_addr       (lsu_addr),
    .i_lsu_wen        (lsu_wen),
    .i_lsu_wdata      (lsu_wdata),
    .i_lsu_wmask      (lsu_wmask),
    .o_lsu_resp_valid (lsu_rv),
    .o_lsu_rdata      (lsu_rd),
    .o_mem_req_valid  (mem_v),
    .i_mem_req_ready  (mem_rdy),
    .o_mem_addr       (mem_addr),
    .o_mem_wen        (mem_wen),
    .o_mem_wdata      (mem_wdata),
    .o_mem_wmask      (mem_wmask),
    .i_mem_resp_valid (mem_rv),
    .i_mem_rdata      (mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference: is a transaction outstanding, has memory
  // accepted it, who owns it, what it carries, and the LSU-over-IFU streak.
  bit            m_busy, m_acc, m_owner_lsu;
  int            m_streak;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;

  // Stimulus knobs for the automatic requesters and memory.
  bit auto_req, auto_mem, spur_en, auto_rst;
  int req_prob, rdy_prob, max_dly, mem_dly;

  // Per-cycle samples for directed checks, and the log of observed grants (0=IFU, 1=LSU).
  logic          s_ifu_rdy, s_lsu_rdy, s_mem_v, s_ifu_rv, s_lsu_rv;
  logic [DW-1:0] s_ifu_rd, s_lsu_rd;
  logic [1:0]    glog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, advance the
  // model on the edge, then drive the next cycle's automatic stimulus.
  task automatic tick();
    bit e_ir, e_lr, e_mv, e_irv, e_lrv;
    @(negedge clk);
    e_ir = 1'b0;
    e_lr = 1'b0;
    if (!m_busy && !reset) begin
      if (ifu_v && lsu_v) begin
        if (m_streak == LIM) e_ir = 1'b1; else e_lr = 1'b1;
      end else if (ifu_v) e_ir = 1'b1;
      else if (lsu_v)     e_lr = 1'b1;
    end
    e_mv  = m_busy && !m_acc && !reset;
    e_irv = m_busy && m_acc && mem_rv && !reset && !m_owner_lsu;
    e_lrv = m_busy && m_acc && mem_rv && !reset &&  m_owner_lsu;

    check("ifu_req_ready",  ifu_rdy, e_ir);
    check("lsu_req_ready",  lsu_rdy, e_lr);
    check("mem_req_valid",  mem_v,   e_mv);
    check("ifu_resp_valid", ifu_rv,  e_irv);
    check("lsu_resp_valid", lsu_rv,  e_lrv);
    check("ifu_rdata",      ifu_rd,  e_irv ? mem_rdata : '0);
    check("lsu_rdata",      lsu_rd,  e_lrv ? mem_rdata : '0);
    if (e_mv) begin
      check("mem_addr",  mem_addr,  m_addr);
      check("mem_wen",   mem_wen,   m_wen);
      check("mem_wmask", mem_wmask, m_wmask);
      if (m_owner_lsu) check("mem_wdata", mem_wdata, m_wdata);
    end

    if (ifu_rdy === 1'b1) glog.push_back(2'd0);
    if (lsu_rdy === 1'b1) glog.push_back(2'd1);
    s_ifu_rdy = ifu_rdy; s_lsu_rdy = lsu_rdy; s_mem_v = mem_v;
    s_ifu_rv  = ifu_rv;  s_lsu_rv  = lsu_rv;
    s_ifu_rd  = ifu_rd;  s_lsu_rd  = lsu_rd;

    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_acc = 1'b0; m_streak = 0;
    end else if (e_ir || e_lr) begin
      m_busy = 1'b1; m_acc = 1'b0; m_owner_lsu = e_lr;
      if (e_lr) begin
        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        if (ifu_v) m_streak = (m_streak + 1 > LIM) ? LIM : m_streak + 1;
      end else begin
        m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        m_streak = 0;
      end
    end else if (m_busy && !m_acc && mem_rdy) begin
      m_acc   = 1'b1;
      mem_dly = $urandom_range(max_dly, 0);
    end else if (m_busy && m_acc && mem_rv) begin
      m_busy = 1'b0;
    end

    #1;
    if (auto_rst) reset = ($urandom_range(149) == 0);
    if (auto_req) begin
      if (e_ir) ifu_v = 1'b0;
      if (e_lr) lsu_v = 1'b0;
      if (!ifu_v && $urandom_range(99) < req_prob) begin
        ifu_v = 1'b1; ifu_addr = $urandom;
      end
      if (!lsu_v && $urandom_range(99) < req_prob) begin
        lsu_v = 1'b1; lsu_addr = $urandom; lsu_wen = $urandom_range(1);
        lsu_wdata = $urandom; lsu_wmask = MW'($urandom);
      end
    end
    if (auto_mem) begin
      mem_rdy   = (m_busy && !m_acc) ? ($urandom_range(99) < rdy_prob) : 1'($urandom_range(1));
      mem_rdata = $urandom;
      if (m_busy && m_acc) begin
        if (mem_dly == 0) mem_rv = 1'b1;
        else begin mem_rv = 1'b0; mem_dly--; end
      end else begin
        // Stray pulses only where the protocol tolerates them: idle or a stalled request.
        mem_rv = spur_en && ($urandom_range(7) == 0) && !(m_busy && mem_rdy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_order [10];
    int n_mv, cyc;

    reset = 1'b1;
    ifu_v = 0; ifu_addr = '0;
    lsu_v = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_rdy = 0; mem_rv = 0; mem_rdata = '0;
    auto_req = 0; auto_mem = 0; spur_en = 0; auto_rst = 0;
    req_prob = 0; rdy_prob = 0; max_dly = 0; mem_dly = 0;
    m_busy = 0; m_acc = 0; m_owner_lsu = 0; m_streak = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
    @(posedge clk); #1;

    // Reset state: a requester waiting under reset is not granted; payload registers clear.
    ifu_v = 1'b1;
    tick();
    check("rst_ifu_ready", s_ifu_rdy, 1'b0);
    check("rst_mem_addr",  mem_addr,  '0);
    check("rst_mem_wen",   mem_wen,   1'b0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_mem_wmask", mem_wmask, '0);
    ifu_v = 1'b0;
    reset = 1'b0;
    tick();

    // Single IFU read with minimum latency.
    ifu_v = 1'b1; ifu_addr = 32'h8000_0000; mem_rdy = 1'b1;
    tick();
    check("t1_c0_ifu_ready", s_ifu_rdy, 1'b1);
    ifu_v = 1'b0;
    tick();
    check("t1_c1_mem_valid", s_mem_v, 1'b1);
    mem_rdy = 1'b0; mem_rv = 1'b1; mem_rdata = 32'h0000_0413;
    tick();
    check("t1_c2_ifu_resp",  s_ifu_rv, 1'b1);
    check("t1_c2_ifu_rdata", s_ifu_rd, 32'h0000_0413);
    check("t1_c2_lsu_resp",  s_lsu_rv, 1'b0);
    mem_rv = 1'b0; mem_rdata = '0;
    tick();

    // LSU store held through three stalled cycles, then one handshake.
    lsu_v = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
    n_mv = 0;
    tick();
    check("t2_lsu_ready", s_lsu_rdy, 1'b1);
    lsu_v = 1'b0; lsu_addr = 32'h1234_5678; lsu_wdata = '0; lsu_wmask = '0; lsu_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_mv += int'(s_mem_v);
    end
    check("t2_held_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_held_wmask", mem_wmask, 4'h3);
    check("t2_held_wen",   mem_wen,   1'b1);
    mem_rdy = 1'b1;
    tick();
    n_mv += int'(s_mem_v);
    mem_rdy = 1'b0;
    tick();
    n_mv += int'(s_mem_v);
    mem_rv = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    n_mv += int'(s_mem_v);
    check("t2_req_cycles", n_mv, 4);
    check("t2_lsu_resp",   s_lsu_rv, 1'b1);
    mem_rv = 1'b0;
    tick();

    // Stray responses in IDLE and in a stalled REQ are ignored.
    mem_rv = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    check("t6_idle_ifu_resp", s_ifu_rv, 1'b0);
    check("t6_idle_lsu_resp", s_lsu_rv, 1'b0);
    mem_rv = 1'b0; ifu_v = 1'b1; ifu_addr = 32'h8000_0040;
    tick();
    ifu_v = 1'b0; mem_rv = 1'b1;
    tick();
    check("t6_req_still_valid", s_mem_v, 1'b1);
    check("t6_req_ifu_resp",    s_ifu_rv, 1'b0);
    mem_rv = 1'b0; mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0; mem_rv = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    check("t6_real_resp", s_ifu_rv, 1'b1);
    mem_rv = 1'b0;
    tick();

    // Slow memory: an IFU request arriving mid-transaction waits for IDLE.
    lsu_v = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; mem_rdy = 1'b1;
    tick();
    lsu_v = 1'b0; ifu_v = 1'b1; ifu_addr = 32'h8000_0080;
    tick();
    mem_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_wait_ifu_ready", s_ifu_rdy, 1'b0);
    end
    mem_rv = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    check("t4_lsu_resp",        s_lsu_rv,  1'b1);
    check("t4_resp_ifu_ready",  s_ifu_rdy, 1'b0);
    mem_rv = 1'b0;
    tick();
    check("t4_idle_ifu_ready",  s_ifu_rdy, 1'b1);
    ifu_v = 1'b0; mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0; mem_rv = 1'b1;
    tick();
    mem_rv = 1'b0;
    tick();

    // Reset in WAIT drops the transaction; a stray response afterwards is ignored.
    lsu_v = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b1;
    lsu_wdata = 32'h7777_8888; lsu_wmask = 4'hF; mem_rdy = 1'b1;
    tick();
    lsu_v = 1'b0;
    tick();
    mem_rdy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("t5_rst_lsu_resp",  s_lsu_rv, 1'b0);
    check("t5_rst_mem_addr",  mem_addr, '0);
    check("t5_rst_mem_wen",   mem_wen,  1'b0);
    check("t5_rst_mem_wmask", mem_wmask, '0);
    reset = 1'b0; mem_rv = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    check("t5_stray_lsu_resp", s_lsu_rv, 1'b0);
    check("t5_stray_mem_v",    s_mem_v,  1'b0);
    mem_rv = 1'b0;
    lsu_v = 1'b1; lsu_addr = 32'h8000_3004; lsu_wen = 1'b0; mem_rdy = 1'b1;
    tick();
    check("t5_regrant", s_lsu_rdy, 1'b1);
    lsu_v = 1'b0;
    tick();
    mem_rdy = 1'b0; mem_rv = 1'b1;
    tick();
    mem_rv = 1'b0;
    tick();

    // Both requesters continuously valid: LSU x4, IFU, LSU x4, IFU.
    exp_order = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    glog.delete();
    auto_req = 1; req_prob = 100; auto_mem = 1; rdy_prob = 100; max_dly = 0; spur_en = 0;
    ifu_v = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_v = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
    cyc = 0;
    while (glog.size() < 10 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t3_grant_budget", (glog.size() >= 10), 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_grant_%0d", i), (i < glog.size()) ? glog[i] : 2'b11, exp_order[i]);
    end

    // Randomized traffic: random requests, memory stalls and delays, strays, resets.
    req_prob = 40; rdy_prob = 60; max_dly = 4; spur_en = 1; auto_rst = 1;
    for (int i = 0; i < 800; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
